// File: rtl/rx_frontend.sv
// UART receive front end: synchronises the serial line, detects start bits, samples mid-bit,
// checks parity/stop bits and delivers each character as a one-cycle valid pulse with error flags.
module rx_frontend (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] cr_clk_div_i,
  input  logic        cr_ds_i,
  input  logic [1:0]  cr_p_i,
  input  logic        cr_s_i,
  input  logic        uart_rx_i,
  output logic [7:0]  dr_o,
  output logic        output_valid_o,
  output logic        pe_o,
  output logic        fe_o
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_prev;
  logic [15:0] r_div;
  logic [15:0] r_cnt;
  logic        r_ds;
  logic [1:0]  r_p;
  logic        r_s;
  logic [7:0]  r_shift;
  logic [2:0]  r_bitcnt;
  logic        r_pe;
  logic        r_fe;

  logic        w_rx;
  logic        w_edge;
  logic        w_tick;
  logic        w_last_bit;
  logic        w_done;
  logic [15:0] w_div_in;

  assign w_rx       = r_sync2;
  assign w_edge     = r_prev & ~r_sync2;
  assign w_tick     = (r_cnt == '0);
  assign w_last_bit = (r_bitcnt == (r_ds ? 3'd6 : 3'd7));
  assign w_div_in   = (cr_clk_div_i < 16'd2) ? 16'd2 : cr_clk_div_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    case (r_state)
      IDLE:   if (w_edge) w_next = START;
      START:  if (w_tick) w_next = w_rx ? IDLE : DATA;
      DATA:   if (w_tick && w_last_bit) w_next = r_p[1] ? PARITY : STOP1;
      PARITY: if (w_tick) w_next = STOP1;
      STOP1: begin
        if (w_tick) begin
          if (r_s) begin
            w_next = STOP2;
          end else begin
            w_next = IDLE;
            w_done = 1'b1;
          end
        end
      end
      STOP2: begin
        if (w_tick) begin
          w_next = IDLE;
          w_done = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1        <= 1'b1;
      r_sync2        <= 1'b1;
      r_prev         <= 1'b1;
      r_div          <= 16'd2;
      r_cnt          <= '0;
      r_ds           <= 1'b0;
      r_p            <= '0;
      r_s            <= 1'b0;
      r_shift        <= '0;
      r_bitcnt       <= '0;
      r_pe           <= 1'b0;
      r_fe           <= 1'b0;
      dr_o           <= '0;
      output_valid_o <= 1'b0;
      pe_o           <= 1'b0;
      fe_o           <= 1'b0;
    end else begin
      r_sync1        <= uart_rx_i;
      r_sync2        <= r_sync1;
      r_prev         <= r_sync2;
      output_valid_o <= 1'b0;
      if (r_state == IDLE) begin
        if (w_edge) begin
          r_div    <= w_div_in;
          r_ds     <= cr_ds_i;
          r_p      <= cr_p_i;
          r_s      <= cr_s_i;
          r_cnt    <= (w_div_in >> 1) - 16'd1;
          r_shift  <= '0;
          r_bitcnt <= '0;
          r_pe     <= 1'b0;
          r_fe     <= 1'b0;
        end
      end else if (w_tick) begin
        r_cnt <= r_div - 16'd1;
        case (r_state)
          DATA: begin
            r_shift[r_bitcnt] <= w_rx;
            r_bitcnt          <= r_bitcnt + 3'd1;
          end
          PARITY:       r_pe <= ((^r_shift) ^ w_rx) != r_p[0];
          STOP1, STOP2: if (!w_rx) r_fe <= 1'b1;
          default:      ;
        endcase
      end else begin
        r_cnt <= r_cnt - 16'd1;
      end
      // the final stop sample completes the frame, so fold it into fe directly
      if (w_done) begin
        output_valid_o <= 1'b1;
        dr_o           <= r_shift;
        pe_o           <= r_pe;
        fe_o           <= r_fe | ~w_rx;
      end
    end
  end

endmodule

// File: tb/tb_rx_frontend.sv
// Self-checking bench for rx_frontend: frame-level model predicts each valid pulse and the held
// outputs; a negedge compare process checks every cycle, plus literal latency/data pins.
module tb_rx_frontend;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [15:0] cr_clk_div_i = 16'd16;
  logic        cr_ds_i = 1'b0;
  logic [1:0]  cr_p_i = 2'b00;
  logic        cr_s_i = 1'b0;
  logic        uart_rx_i = 1'b1;
  logic [7:0]  dr_o;
  logic        output_valid_o;
  logic        pe_o;
  logic        fe_o;

  rx_frontend dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cr_clk_div_i   (cr_clk_div_i),
    .cr_ds_i        (cr_ds_i),
    .cr_p_i         (cr_p_i),
    .cr_s_i         (cr_s_i),
    .uart_rx_i      (uart_rx_i),
    .dr_o           (dr_o),
    .output_valid_o (output_valid_o),
    .pe_o           (pe_o),
    .fe_o           (fe_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int         cyc;
    logic [7:0] dr;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t       expq[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic       started = 1'b0;
  logic [7:0] held_dr = '0;
  logic       held_pe = 1'b0;
  logic       held_fe = 1'b0;
  int         nvalid = 0;
  int         obs_cyc = 0;
  logic [7:0] obs_dr = '0;
  logic       obs_pe = 1'b0;
  logic       obs_fe = 1'b0;

  always @(posedge clk_i) begin
    cyc = cyc + 1;
    if (rst_i) begin
      started = 1'b1;
      held_dr = '0;
      held_pe = 1'b0;
      held_fe = 1'b0;
      expq.delete();
    end
  end

  always @(negedge clk_i) begin
    logic exp_v;
    if (started) begin
      exp_v = 1'b0;
      if (expq.size() > 0 && expq[0].cyc == cyc) begin
        exp_v   = 1'b1;
        held_dr = expq[0].dr;
        held_pe = expq[0].pe;
        held_fe = expq[0].fe;
        void'(expq.pop_front());
      end
      checks = checks + 1;
      if ({output_valid_o, dr_o, pe_o, fe_o} !== {exp_v, held_dr, held_pe, held_fe}) begin
        errors = errors + 1;
        $display("FAIL cycle%0d outputs: got v=%b dr=%h pe=%b fe=%b, want v=%b dr=%h pe=%b fe=%b",
                 cyc, output_valid_o, dr_o, pe_o, fe_o, exp_v, held_dr, held_pe, held_fe);
      end
      if (output_valid_o === 1'b1) begin
        nvalid = nvalid + 1;
        obs_cyc = cyc;
        obs_dr = dr_o;
        obs_pe = pe_o;
        obs_fe = fe_o;
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks = checks + 1;
    if (got != want) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  task automatic tx_bit(input logic b, input int d);
    uart_rx_i = b;
    repeat (d) @(posedge clk_i);
    #1;
  endtask

  // Drives one frame; config is scrambled after the start bit to show it was latched at the edge.
  task automatic send(input int d, input logic [7:0] data, input logic ds, input logic [1:0] p,
                      input logic s, input logic flip, input logic stop_low, output int t0);
    int         nb;
    int         len;
    logic       par;
    logic [7:0] dm;
    exp_t       e;
    cr_clk_div_i = 16'(d);
    cr_ds_i = ds;
    cr_p_i = p;
    cr_s_i = s;
    nb = ds ? 7 : 8;
    dm = ds ? {1'b0, data[6:0]} : data;
    par = (^dm) ^ p[0] ^ flip;
    len = 1 + nb + int'(p[1]) + 1 + int'(s);
    t0 = cyc;
    e.cyc = t0 + 2 + d / 2 + (len - 1) * d + 1;
    e.dr = dm;
    e.pe = p[1] & flip;
    e.fe = stop_low;
    expq.push_back(e);
    tx_bit(1'b0, d);
    cr_clk_div_i = 16'(d * 3);
    cr_ds_i = ~ds;
    cr_p_i = ~p;
    cr_s_i = ~s;
    for (int i = 0; i < nb; i++) tx_bit(dm[i], d);
    if (p[1]) tx_bit(par, d);
    tx_bit(~stop_low, d);
    if (s) tx_bit(~stop_low, d);
    cr_clk_div_i = 16'(d);
    cr_ds_i = ds;
    cr_p_i = p;
    cr_s_i = s;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int nv;
    repeat (4) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    chk("reset dr", int'(dr_o), 0);
    chk("reset flags", int'({output_valid_o, pe_o, fe_o}), 0);

    send(16, 8'hA5, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, t);
    tx_bit(1'b1, 16);
    chk("8N1 latency", obs_cyc - (t + 2), 153);
    chk("8N1 dr", int'(obs_dr), 8'hA5);
    chk("8N1 pe/fe", int'({obs_pe, obs_fe}), 0);

    send(16, 8'h41, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, t);
    tx_bit(1'b1, 16);
    chk("7E2 latency", obs_cyc - (t + 2), 169);
    chk("7E2 dr", int'(obs_dr), 8'h41);
    chk("7E2 pe", int'(obs_pe), 0);
    send(16, 8'h41, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, t);
    tx_bit(1'b1, 16);
    chk("7E2 flipped pe", int'(obs_pe), 1);
    chk("7E2 flipped dr", int'(obs_dr), 8'h41);

    send(16, 8'h00, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, t);
    tx_bit(1'b1, 16);
    chk("8O1 good pe", int'(obs_pe), 0);
    send(16, 8'h00, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, t);
    tx_bit(1'b1, 16);
    chk("8O1 bad pe", int'(obs_pe), 1);

    nv = nvalid;
    send(16, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, t);
    repeat (40 * 16) @(posedge clk_i);
    #1;
    chk("break pulses", nvalid - nv, 1);
    chk("break dr/fe", int'({obs_dr, obs_fe}), 9'h001);
    tx_bit(1'b1, 32);
    send(16, 8'h3C, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, t);
    tx_bit(1'b1, 16);
    chk("after break dr", int'(obs_dr), 8'h3C);
    chk("after break fe", int'(obs_fe), 0);

    nv = nvalid;
    cr_clk_div_i = 16'd16;
    uart_rx_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    tx_bit(1'b1, 48);
    chk("glitch pulses", nvalid - nv, 0);
    chk("glitch dr held", int'(dr_o), 8'h3C);

    nv = nvalid;
    send(10, 8'h55, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, t);
    chk("b2b first dr", int'(obs_dr), 8'h55);
    chk("b2b first latency", obs_cyc - (t + 2), 96);
    send(10, 8'hAA, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, t);
    chk("b2b second dr", int'(obs_dr), 8'hAA);
    cr_clk_div_i = 16'd10;
    tx_bit(1'b0, 10);
    tx_bit(1'b1, 10);
    tx_bit(1'b0, 5);
    uart_rx_i = 1'b1;
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    tx_bit(1'b1, 150);
    chk("b2b pulses", nvalid - nv, 2);
    chk("post-reset dr", int'(dr_o), 0);
    chk("post-reset flags", int'({output_valid_o, pe_o, fe_o}), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
